// File: rtl/dac_wavegen_pkg.sv
// Shared types and constants for the 4-channel DAC waveform generator.
// Holds wave codes, engine states, per-channel config layout and clamp limits.
package dac_wavegen_pkg;

  localparam int PH_W_DEF   = 32;
  localparam int SMP_W      = 16;
  localparam int CE_DIV_MIN = 1024;

  localparam logic signed [17:0] SAT_MAX = 18'sd32767;
  localparam logic signed [17:0] SAT_MIN = -18'sd32768;

  typedef enum logic [1:0] {
    WAVE_DC  = 2'd0,
    WAVE_SAW = 2'd1,
    WAVE_TRI = 2'd2,
    WAVE_SQR = 2'd3
  } wave_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_SHAPE,
    ST_MULT,
    ST_SAT,
    ST_UPDATE
  } state_e;

  typedef struct packed {
    logic [1:0]  wave;
    logic [31:0] inc;
    logic [15:0] amp;
    logic [15:0] offset;
  } cfg_t;

endpackage

// File: rtl/dac_wave_shaper.sv
// Time-shared SHAPE -> MULT -> SAT datapath; one channel in flight at a time.
// Shape and product are registered; the offset/clamp stage is combinational off the product.
module dac_wave_shaper
  import dac_wavegen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_shape_en,
  input  logic        i_mult_en,
  input  logic [1:0]  i2_wave,
  input  logic [15:0] i16_phase,
  input  logic [15:0] i16_amp,
  input  logic [15:0] is16_offset,
  output logic [15:0] os16_sample,
  output logic        o_sat
);

  logic signed [15:0] w_q, w_d;
  logic signed [16:0] prod_q, prod_d;
  logic        [15:0] ramp;
  logic signed [32:0] prod_full;
  logic signed [17:0] sum;

  always_comb begin
    w_d         = w_q;
    prod_d      = prod_q;
    ramp        = {i16_phase[14:0], 1'b0};
    prod_full   = w_q * $signed({1'b0, i16_amp});
    sum         = $signed({prod_q[16], prod_q}) + $signed({{2{is16_offset[15]}}, is16_offset});
    o_sat       = 1'b0;
    os16_sample = sum[15:0];

    if (i_shape_en) begin
      case (i2_wave)
        WAVE_DC:  w_d = 16'sh7FFF;
        WAVE_SAW: w_d = $signed(i16_phase ^ 16'h8000);
        // Modulo-2^16 subtraction gives the signed ramp directly in both halves.
        WAVE_TRI: w_d = i16_phase[15] ? $signed(16'h7FFF - ramp) : $signed(ramp - 16'h8000);
        default:  w_d = i16_phase[15] ? 16'sh8000 : 16'sh7FFF;
      endcase
    end

    if (i_mult_en) begin
      prod_d = 17'(prod_full >>> 16);
    end

    if (sum > SAT_MAX) begin
      os16_sample = 16'h7FFF;
      o_sat       = 1'b1;
    end else if (sum < SAT_MIN) begin
      os16_sample = 16'h8000;
      o_sat       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q    <= '0;
      prod_q <= '0;
    end else begin
      w_q    <= w_d;
      prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/dac_wavegen_4ch.sv
// Four-channel waveform generator: sample divider, config banks, accumulators and engine FSM.
// Samples appear 18 cycles after each divider tick with a one-cycle o_ce; outputs hold in between.
module dac_wavegen_4ch
  import dac_wavegen_pkg::*;
#(
  parameter int CE_DIV = 2000,
  parameter int PH_W   = PH_W_DEF
) (
  input  logic        clk100mhz,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_cfg_we,
  input  logic [1:0]  i2_cfg_ch,
  input  logic [1:0]  i2_cfg_wave,
  input  logic [31:0] i32_cfg_phase_inc,
  input  logic [15:0] i16_cfg_amp,
  input  logic [15:0] is16_cfg_offset,
  input  logic        i_sat_clr,
  output logic        o_ce,
  output logic [15:0] os16_data_ch0,
  output logic [15:0] os16_data_ch1,
  output logic [15:0] os16_data_ch2,
  output logic [15:0] os16_data_ch3,
  output logic        o_cfg_pending,
  output logic [3:0]  o4_sat
);

  generate
    if (CE_DIV < CE_DIV_MIN) begin : g_bad_div
      $error("CE_DIV shorter than the driver's 4-channel write time");
    end
    if (PH_W < 16 || PH_W > 32) begin : g_bad_ph
      $error("PH_W must be within 16..32");
    end
  endgenerate

  localparam int CNT_W = $clog2(CE_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  state_e           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  cfg_t             shd_q[4], shd_d[4];
  cfg_t             act_q[4], act_d[4];
  logic [PH_W-1:0]  acc_q[4], acc_d[4];
  logic             pend_q, pend_d;
  logic [15:0]      res_q[4], res_d[4];
  logic [15:0]      out_q[4], out_d[4];
  logic             ce_q, ce_d;
  logic [3:0]       sat_q, sat_d;

  cfg_t        cur;
  logic [15:0] sample;
  logic        sample_sat;

  assign cur = act_q[ch_q];

  dac_wave_shaper u_shaper (
    .clk         (clk100mhz),
    .rst         (rst),
    .i_shape_en  (state_q == ST_SHAPE),
    .i_mult_en   (state_q == ST_MULT),
    .i2_wave     (cur.wave),
    .i16_phase   (acc_q[ch_q][PH_W-1 -: 16]),
    .i16_amp     (cur.amp),
    .is16_offset (cur.offset),
    .os16_sample (sample),
    .o_sat       (sample_sat)
  );

  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    state_d = state_q;
    ch_d    = ch_q;
    shd_d   = shd_q;
    act_d   = act_q;
    acc_d   = acc_q;
    pend_d  = pend_q;
    res_d   = res_q;
    out_d   = out_q;
    ce_d    = 1'b0;
    sat_d   = sat_q;

    if (i_enable) begin
      if (cnt_q == '0) begin
        cnt_d  = CNT_W'(CE_DIV - 1);
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // A write landing on the tick edge goes to shadow only, so pending must survive the copy.
    if (tick_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (i_cfg_we) begin
      shd_d[i2_cfg_ch] = '{wave: i2_cfg_wave, inc: i32_cfg_phase_inc,
                           amp: i16_cfg_amp, offset: is16_cfg_offset};
      pend_d = 1'b1;
    end

    if (i_sat_clr) begin
      sat_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick_q) begin
          state_d = ST_ACC;
          ch_d    = 2'd0;
        end
      end
      ST_ACC: begin
        acc_d[ch_q] = acc_q[ch_q] + cur.inc[PH_W-1:0];
        state_d     = ST_SHAPE;
      end
      ST_SHAPE: state_d = ST_MULT;
      ST_MULT:  state_d = ST_SAT;
      ST_SAT: begin
        res_d[ch_q] = sample;
        if (sample_sat) begin
          sat_d[ch_q] = 1'b1;
        end
        if (ch_q == 2'd3) begin
          state_d = ST_UPDATE;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = ST_ACC;
        end
      end
      ST_UPDATE: begin
        out_d   = res_q;
        ce_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      cnt_q   <= CNT_W'(CE_DIV - 1);
      tick_q  <= 1'b0;
      state_q <= ST_IDLE;
      ch_q    <= 2'd0;
      pend_q  <= 1'b0;
      ce_q    <= 1'b0;
      sat_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        shd_q[i] <= '0;
        act_q[i] <= '0;
        acc_q[i] <= '0;
        res_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      pend_q  <= pend_d;
      ce_q    <= ce_d;
      sat_q   <= sat_d;
      shd_q   <= shd_d;
      act_q   <= act_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      out_q   <= out_d;
    end
  end

  assign o_ce          = ce_q;
  assign os16_data_ch0 = out_q[0];
  assign os16_data_ch1 = out_q[1];
  assign os16_data_ch2 = out_q[2];
  assign os16_data_ch3 = out_q[3];
  assign o_cfg_pending = pend_q;
  assign o4_sat        = sat_q;

endmodule

// File: tb/tb_dac_wavegen_4ch.sv
// Directed bench for dac_wavegen_4ch: expected strobes are queued as stimulus is issued,
// and a negedge monitor pops one record per o_ce and compares timing, samples and flags.
module tb_dac_wavegen_4ch;

  localparam int CE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        we  = 1'b0;
  logic [1:0]  cch = '0;
  logic [1:0]  cwave = '0;
  logic [31:0] cinc = '0;
  logic [15:0] camp = '0;
  logic [15:0] coff = '0;
  logic        clr = 1'b0;

  logic        ce;
  logic [15:0] d0, d1, d2, d3;
  logic        pend;
  logic [3:0]  sat;

  dac_wavegen_4ch #(.CE_DIV(CE), .PH_W(32)) dut (
    .clk100mhz         (clk),
    .rst               (rst),
    .i_enable          (en),
    .i_cfg_we          (we),
    .i2_cfg_ch         (cch),
    .i2_cfg_wave       (cwave),
    .i32_cfg_phase_inc (cinc),
    .i16_cfg_amp       (camp),
    .is16_cfg_offset   (coff),
    .i_sat_clr         (clr),
    .o_ce              (ce),
    .os16_data_ch0     (d0),
    .os16_data_ch1     (d1),
    .os16_data_ch2     (d2),
    .os16_data_ch3     (d3),
    .o_cfg_pending     (pend),
    .o4_sat            (sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cyc;
    int v0, v1, v2, v3;
    int sat;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_ce(input int c, input int a0, input int a1, input int a2,
                           input int a3, input int s);
    exp_t e;
    e.cyc = c; e.v0 = a0; e.v1 = a1; e.v2 = a2; e.v3 = a3; e.sat = s;
    q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] w, input logic [31:0] inc,
                     input logic [15:0] amp, input logic [15:0] off);
    we = 1'b1; cch = ch; cwave = w; cinc = inc; camp = amp; coff = off;
    @(negedge clk);
    we = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ce === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ce: strobe at cycle %0d, none expected", cyc);
      end else begin
        e = q.pop_front();
        chk("ce_cycle", cyc, e.cyc);
        chk("ch0", $signed(d0), e.v0);
        chk("ch1", $signed(d1), e.v1);
        chk("ch2", $signed(d2), e.v2);
        chk("ch3", $signed(d3), e.v3);
        chk("sat", int'(sat), e.sat);
      end
    end
  end

  initial begin
    int e1, e2, e3, e5, e7, e8, e9, er;

    repeat (3) @(negedge clk);
    chk("rst_ce", int'(ce), 0);
    chk("rst_ch0", int'(d0), 0);
    chk("rst_ch1", int'(d1), 0);
    chk("rst_ch2", int'(d2), 0);
    chk("rst_ch3", int'(d3), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_sat", int'(sat), 0);
    rst = 1'b0;
    @(negedge clk);

    en = 1'b1;
    e1 = cyc + CE + 18;
    expect_ce(e1, 0, 0, 0, 0, 0);

    wait_until(e1 + 2);
    chk("pend_idle", int'(pend), 0);
    cfg(2'd0, 2'd0, 32'h0, 16'hFFFF, 16'h0);
    chk("pend_set", int'(pend), 1);
    cfg(2'd1, 2'd1, 32'h4000_0000, 16'hFFFF, 16'h0);
    cfg(2'd2, 2'd3, 32'h8000_0000, 16'hFFFF, 16'h7000);
    cfg(2'd3, 2'd2, 32'h4000_0000, 16'hFFFF, 16'h0);

    e2 = e1 + CE;
    e3 = e2 + CE;
    e5 = e3 + 2 * CE;
    e7 = e5 + 2 * CE;
    e8 = e7 + CE;
    e9 = e8 + CE;
    expect_ce(e2,      32766, -16384, -4096,      0, 0);
    expect_ce(e3,      32766,      0, 32767,  32766, 4);
    expect_ce(e3 + CE, 32766,  16383, -4096,     -1, 0);
    expect_ce(e5,      32766, -32768, 32767, -32768, 4);
    expect_ce(e5 + CE, 32766, -16384, -4096,      0, 0);
    expect_ce(e7,      32766,      0, 32767,  32766, 4);
    expect_ce(e8,     -16384,  16383, -4096,     -1, 4);

    wait_until(e2 - 18);
    chk("pend_before_tick", int'(pend), 1);
    @(negedge clk);
    chk("pend_after_tick", int'(pend), 0);

    wait_until(e3 + 2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("sat_clr_a", int'(sat), 0);

    wait_until(e5 + 2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("sat_clr_b", int'(sat), 0);

    // Write lands on the tick edge of strobe 7: old ch0 config used, new at strobe 8.
    wait_until(e7 - 18);
    cfg(2'd0, 2'd3, 32'h8000_0000, 16'h8000, 16'h0);
    chk("pend_tick_write", int'(pend), 1);

    // Clear coincides with the channel-2 clamp; the set must win.
    wait_until(e7 - 6);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    wait_until(e8 - 18);
    chk("pend_held", int'(pend), 1);
    @(negedge clk);
    chk("pend_applied", int'(pend), 0);

    wait_until(e9 - 9);
    rst = 1'b1;
    #1;
    chk("midrst_ce", int'(ce), 0);
    chk("midrst_ch0", int'(d0), 0);
    chk("midrst_ch1", int'(d1), 0);
    chk("midrst_ch2", int'(d2), 0);
    chk("midrst_sat", int'(sat), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    er = cyc + CE + 18;
    expect_ce(er, 0, 0, 0, 0, 0);

    wait_until(er + 4);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
